fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 tb/tb_fifo_stream_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Two-entry skid buffer that pops words from a FIFO read port and presents
// them as a valid/ready stream. m_data is always a registered value, and
// fifo_rd_en never depends on m_ready, so neither side has a combinational
// path through this block.
module fifo_stream_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pop;
  logic out;

  // Pop only when there is room; rstn gating keeps the FIFO untouched during reset.
  assign pop        = rstn && !fifo_empty && (state_q != StTwo) && !flush;
  assign out        = m_valid && m_ready;
  assign fifo_rd_en = pop;
  assign m_valid    = (state_q != StEmpty);
  assign m_data     = head_q;
  assign xfer_count = cnt_q;

  // Occupancy FSM and buffer next-state; flush overrides to empty.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (pop) begin
            head_d  = fifo_rd_data;
            state_d = StOne;
          end
        end
        StOne: begin
          if (pop && out) begin
            head_d = fifo_rd_data;
          end else if (pop) begin
            tail_d  = fifo_rd_data;
            state_d = StTwo;
          end else if (out) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Transfer counter; a transfer in a flush cycle still counts, wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (out) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StEmpty;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a small array-backed FIFO model feeds
// the DUT; a second instance with a 4-bit counter covers counter wrap.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rstn;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       flush;
  logic [15:0] xfer_count;

  logic       fifo_rd_en4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic [3:0] xfer_count4;

  // FIFO model
  logic [7:0] mem [0:255];
  logic [7:0] rd_ptr;
  logic [7:0] wr_ptr;
  logic       hide;

  int n_cmp;
  int n_fail;

  logic [7:0] got [0:31];
  logic [7:0] exp_s [0:31];
  int         n_got;
  logic [7:0] rd_start;

  assign fifo_empty   = (rd_ptr == wr_ptr) || hide;
  assign fifo_rd_data = mem[rd_ptr];

  fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .flush        (flush),
    .xfer_count   (xfer_count)
  );

  fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en4),
    .m_valid      (m_valid4),
    .m_ready      (m_ready),
    .m_data       (m_data4),
    .flush        (flush),
    .xfer_count   (xfer_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO read pointer advances on every accepted pop.
  always @(posedge clk) begin
    if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rd_ptr  = 8'd0;
    wr_ptr  = 8'd0;
    hide    = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    rstn    = 1'b1;
    #1 rstn = 1'b0;

    // Reset state, with FIFO already non-empty
    push(8'h11); push(8'h22); push(8'h33);
    m_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_cnt", 32'(xfer_count), 32'd0);
    chk("rst_rden", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid4", 32'(m_valid4), 32'd0);

    // Stream 0x11,0x22,0x33
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("s_rden0", 32'(fifo_rd_en), 32'd1);
    chk("s_valid0", 32'(m_valid), 32'd0);
    cyc();
    chk("s_data1", 32'(m_data), 32'h11);
    chk("s_rden1", 32'(fifo_rd_en), 32'd1);
    cyc();
    chk("s_data2", 32'(m_data), 32'h22);
    chk("s_rden2", 32'(fifo_rd_en), 32'd1);
    cyc();
    chk("s_data3", 32'(m_data), 32'h33);
    chk("s_rden3", 32'(fifo_rd_en), 32'd0);
    cyc();
    chk("s_valid_end", 32'(m_valid), 32'd0);
    chk("s_cnt", 32'(xfer_count), 32'd3);

    // Backpressure: 4 words, sink stalled
    m_ready  = 1'b0;
    rd_start = rd_ptr;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    cyc();
    chk("bp_data_a", 32'(m_data), 32'h41);
    cyc();
    chk("bp_rden_two", 32'(fifo_rd_en), 32'd0);
    chk("bp_data_b", 32'(m_data), 32'h41);
    cyc();
    chk("bp_pops", 32'(rd_ptr - rd_start), 32'd2);
    chk("bp_data_hold", 32'(m_data), 32'h41);
    chk("bp_valid_hold", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    cyc();
    chk("bp_data1", 32'(m_data), 32'h42);
    cyc();
    chk("bp_data2", 32'(m_data), 32'h43);
    cyc();
    chk("bp_data3", 32'(m_data), 32'h44);
    cyc();
    chk("bp_valid_end", 32'(m_valid), 32'd0);
    chk("bp_cnt", 32'(xfer_count), 32'd7);

    // Bubble: FIFO empty flag toggles every cycle
    hide = 1'b1;
    push(8'h51); push(8'h52); push(8'h53);
    n_got = 0;
    for (int i = 0; i < 8; i++) begin
      hide = (i % 2 == 1);
      cyc();
      if (m_valid && n_got < 32) begin
        got[n_got] = m_data;
        n_got++;
      end
    end
    hide = 1'b0;
    chk("bub_n", 32'(n_got), 32'd3);
    chk("bub_w0", 32'(got[0]), 32'h51);
    chk("bub_w1", 32'(got[1]), 32'h52);
    chk("bub_w2", 32'(got[2]), 32'h53);
    chk("bub_cnt", 32'(xfer_count), 32'd10);

    // Flush while TWO with sink stalled
    m_ready = 1'b0;
    push(8'hA0); push(8'hA1); push(8'hA2);
    cyc();
    cyc();
    chk("fl_data_two", 32'(m_data), 32'hA0);
    flush = 1'b1;
    #1;
    chk("fl_rden", 32'(fifo_rd_en), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_valid", 32'(m_valid), 32'd0);
    chk("fl_cnt", 32'(xfer_count), 32'd10);
    chk("fl_rden_after", 32'(fifo_rd_en), 32'd1);
    cyc();
    chk("fl_data_a2", 32'(m_data), 32'hA2);
    // Flush in ONE with a transfer in the same cycle; FIFO non-empty
    push(8'hA3);
    flush   = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("fl2_rden", 32'(fifo_rd_en), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    chk("fl2_valid", 32'(m_valid), 32'd0);
    chk("fl2_cnt", 32'(xfer_count), 32'd11);
    cyc();
    chk("fl2_data", 32'(m_data), 32'hA3);
    cyc();
    chk("fl2_cnt_end", 32'(xfer_count), 32'd12);
    chk("fl2_cnt4", 32'(xfer_count4), 32'd12);

    // Async reset mid-stream
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    for (int i = 0; i < 15; i++) push(8'h70 + 8'(i));
    cyc();
    chk("ar_data1", 32'(m_data), 32'h61);
    cyc();
    chk("ar_data2", 32'(m_data), 32'h62);
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(m_valid), 32'd0);
    chk("ar_cnt", 32'(xfer_count), 32'd0);
    chk("ar_data0", 32'(m_data), 32'd0);
    chk("ar_rden", 32'(fifo_rd_en), 32'd0);
    chk("ar_cnt4", 32'(xfer_count4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc();

    // Post-reset stream of 17 words; also wraps the 4-bit counter
    exp_s[0] = 8'h63;
    exp_s[1] = 8'h64;
    for (int i = 0; i < 15; i++) exp_s[i + 2] = 8'h70 + 8'(i);
    n_got = 0;
    for (int i = 0; i < 40; i++) begin
      if (!m_valid) break;
      if (n_got < 32) begin
        got[n_got] = m_data;
        n_got++;
      end
      cyc();
    end
    chk("wr_valid_end", 32'(m_valid), 32'd0);
    chk("wr_n", 32'(n_got), 32'd17);
    for (int i = 0; i < 17; i++) chk($sformatf("wr_w%0d", i), 32'(got[i]), 32'(exp_s[i]));
    chk("wr_cnt", 32'(xfer_count), 32'd17);
    chk("wr_cnt4", 32'(xfer_count4), 32'd1);
    chk("wr_valid4", 32'(m_valid4), 32'd0);
    chk("wr_rden4", 32'(fifo_rd_en4), 32'd0);
    chk("wr_data4", 32'(m_data4), 32'h7E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
